// File: rtl/load_reservation_station_multi_pkg.sv
// Shared constants, FSM encoding and CDB helpers for the
// multi-entry load reservation station.
package load_reservation_station_multi_pkg;

  localparam logic [6:0]  OPCODE_LOAD = 7'b0000011;
  localparam int unsigned TAG_NONE    = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } lrs_state_t;

  // Bit offset of CDB slot `slot` in a bus of `dw`-wide slots.
  function automatic logic [31:0] cdb_lsb(
    input logic [31:0] slot,
    input logic [31:0] dw
  );
    return slot * dw;
  endfunction

endpackage

// File: rtl/load_reservation_station_multi_lrs_entry.sv
// One load slot: operand storage, CDB snoop and issue-time
// bypass, plus the in-flight marker used by the issue FSM.
module lrs_entry
  import load_reservation_station_multi_pkg::*;
#(
  parameter int REORDER_BUFFER_SIZE_LOG  = 4,
  parameter int FUNCTION_UNIT_NUMBER     = 16,
  parameter int FUNCTION_UNIT_NUMBER_LOG = 4,
  parameter int DATA_WIDTH               = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 alloc,
  input  logic                                 take,
  input  logic                                 free,
  input  logic [REORDER_BUFFER_SIZE_LOG-1:0]   issue_pos,
  input  logic [FUNCTION_UNIT_NUMBER_LOG-1:0]  issue_qj,
  input  logic [DATA_WIDTH-1:0]                issue_vj,
  input  logic [FUNCTION_UNIT_NUMBER_LOG-1:0]  issue_qk,
  input  logic [DATA_WIDTH-1:0]                issue_vk,
  input  logic [FUNCTION_UNIT_NUMBER-1:0]      cdb_valid,
  input  logic [FUNCTION_UNIT_NUMBER*DATA_WIDTH-1:0] common_data_bus,
  output logic                                 valid,
  output logic                                 ready,
  output logic [REORDER_BUFFER_SIZE_LOG-1:0]   pos,
  output logic [DATA_WIDTH-1:0]                vj,
  output logic [DATA_WIDTH-1:0]                vk
);

  localparam int TW = FUNCTION_UNIT_NUMBER_LOG;
  localparam logic [TW-1:0] TAG0 = TW'(TAG_NONE);

  logic [TW-1:0]         qj;
  logic [TW-1:0]         qk;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] slot_j;
  logic [DATA_WIDTH-1:0] slot_k;
  logic [DATA_WIDTH-1:0] slot_ij;
  logic [DATA_WIDTH-1:0] slot_ik;
  logic                  hit_j;
  logic                  hit_k;
  logic                  byp_j;
  logic                  byp_k;

  assign slot_j  = common_data_bus[cdb_lsb(32'(qj), DATA_WIDTH) +: DATA_WIDTH];
  assign slot_k  = common_data_bus[cdb_lsb(32'(qk), DATA_WIDTH) +: DATA_WIDTH];
  assign slot_ij = common_data_bus[cdb_lsb(32'(issue_qj), DATA_WIDTH) +: DATA_WIDTH];
  assign slot_ik = common_data_bus[cdb_lsb(32'(issue_qk), DATA_WIDTH) +: DATA_WIDTH];

  // Tag 0 means "value present" and must never match a broadcast.
  assign hit_j = (qj != TAG0) && cdb_valid[qj];
  assign hit_k = (qk != TAG0) && cdb_valid[qk];
  assign byp_j = (issue_qj != TAG0) && cdb_valid[issue_qj];
  assign byp_k = (issue_qk != TAG0) && cdb_valid[issue_qk];

  assign ready = valid && (qj == TAG0) && (qk == TAG0) && !inflight;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= 1'b0;
      inflight <= 1'b0;
      pos      <= '0;
      qj       <= '0;
      qk       <= '0;
      vj       <= '0;
      vk       <= '0;
    end else if (flush) begin
      valid    <= 1'b0;
      inflight <= 1'b0;
    end else if (alloc) begin
      valid    <= 1'b1;
      inflight <= 1'b0;
      pos      <= issue_pos;
      qj       <= byp_j ? TAG0 : issue_qj;
      vj       <= byp_j ? slot_ij : issue_vj;
      qk       <= byp_k ? TAG0 : issue_qk;
      vk       <= byp_k ? slot_ik : issue_vk;
    end else begin
      if (free) begin
        valid    <= 1'b0;
        inflight <= 1'b0;
      end else if (take) begin
        inflight <= 1'b1;
      end
      if (valid && hit_j) begin
        qj <= TAG0;
        vj <= slot_j;
      end
      if (valid && hit_k) begin
        qk <= TAG0;
        vk <= slot_k;
      end
    end
  end

endmodule

// File: rtl/load_reservation_station_multi.sv
// Multi-entry load reservation station: allocation and
// selection encoders plus the single-outstanding load FSM.
module load_reservation_station_multi
  import load_reservation_station_multi_pkg::*;
#(
  parameter int ENTRIES                   = 4,
  parameter int ENTRIES_LOG               = 2,
  parameter int REORDER_BUFFER_SIZE_LOG   = 4,
  parameter int FUNCTION_UNIT_NUMBER      = 16,
  parameter int FUNCTION_UNIT_NUMBER_LOG  = 4,
  parameter int NUMBER_OF_BLOCKS_IN_CACHE = 4,
  parameter int DATA_WIDTH                = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 issue_valid,
  output logic                                 issue_ready,
  input  logic [REORDER_BUFFER_SIZE_LOG-1:0]   issue_pos,
  input  logic [FUNCTION_UNIT_NUMBER_LOG-1:0]  issue_qj,
  input  logic [DATA_WIDTH-1:0]                issue_vj,
  input  logic [FUNCTION_UNIT_NUMBER_LOG-1:0]  issue_qk,
  input  logic [DATA_WIDTH-1:0]                issue_vk,
  input  logic [FUNCTION_UNIT_NUMBER-1:0]      cdb_valid,
  input  logic [FUNCTION_UNIT_NUMBER*DATA_WIDTH-1:0] common_data_bus,
  output logic                                 dcache_read_en,
  output logic [DATA_WIDTH-1:0]                dcache_read_ptr,
  input  logic [DATA_WIDTH-1:0]                dcache_read_value,
  input  logic                                 dcache_read_success,
  input  logic [NUMBER_OF_BLOCKS_IN_CACHE-1:0] dcache_busy,
  output logic                                 wb_valid,
  input  logic                                 wb_ready,
  output logic [REORDER_BUFFER_SIZE_LOG-1:0]   wb_position,
  output logic [DATA_WIDTH-1:0]                wb_value,
  output logic                                 busy
);

  logic [ENTRIES-1:0]               ent_valid;
  logic [ENTRIES-1:0]               ent_ready;
  logic [REORDER_BUFFER_SIZE_LOG-1:0] ent_pos [ENTRIES];
  logic [DATA_WIDTH-1:0]            ent_vj  [ENTRIES];
  logic [DATA_WIDTH-1:0]            ent_vk  [ENTRIES];
  logic [ENTRIES-1:0]               alloc;
  logic [ENTRIES-1:0]               take;
  logic [ENTRIES-1:0]               done;
  logic [ENTRIES_LOG-1:0]           alloc_idx;
  logic [ENTRIES_LOG-1:0]           sel;
  logic [ENTRIES_LOG-1:0]           cur;
  logic [ENTRIES_LOG-1:0]           cur_n;
  lrs_state_t                       state;
  lrs_state_t                       state_n;
  logic                             ren_n;
  logic [DATA_WIDTH-1:0]            ptr_n;
  logic                             wbv_n;
  logic [REORDER_BUFFER_SIZE_LOG-1:0] wbp_n;
  logic [DATA_WIDTH-1:0]            wbd_n;

  assign issue_ready = ~&ent_valid;
  assign busy        = |ent_valid;

  always_comb begin
    alloc_idx = '0;
    sel       = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!ent_valid[i]) alloc_idx = ENTRIES_LOG'(i);
      if (ent_ready[i])  sel       = ENTRIES_LOG'(i);
    end
    alloc            = '0;
    alloc[alloc_idx] = issue_valid && issue_ready && !flush;
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    lrs_entry #(
      .REORDER_BUFFER_SIZE_LOG (REORDER_BUFFER_SIZE_LOG),
      .FUNCTION_UNIT_NUMBER    (FUNCTION_UNIT_NUMBER),
      .FUNCTION_UNIT_NUMBER_LOG(FUNCTION_UNIT_NUMBER_LOG),
      .DATA_WIDTH              (DATA_WIDTH)
    ) u_ent (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .alloc          (alloc[g]),
      .take           (take[g]),
      .free           (done[g]),
      .issue_pos      (issue_pos),
      .issue_qj       (issue_qj),
      .issue_vj       (issue_vj),
      .issue_qk       (issue_qk),
      .issue_vk       (issue_vk),
      .cdb_valid      (cdb_valid),
      .common_data_bus(common_data_bus),
      .valid          (ent_valid[g]),
      .ready          (ent_ready[g]),
      .pos            (ent_pos[g]),
      .vj             (ent_vj[g]),
      .vk             (ent_vk[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      cur             <= '0;
      dcache_read_en  <= 1'b0;
      dcache_read_ptr <= '0;
      wb_valid        <= 1'b0;
      wb_position     <= '0;
      wb_value        <= '0;
    end else begin
      state           <= state_n;
      cur             <= cur_n;
      dcache_read_en  <= ren_n;
      dcache_read_ptr <= ptr_n;
      wb_valid        <= wbv_n;
      wb_position     <= wbp_n;
      wb_value        <= wbd_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    ren_n   = dcache_read_en;
    ptr_n   = dcache_read_ptr;
    wbv_n   = wb_valid;
    wbp_n   = wb_position;
    wbd_n   = wb_value;
    take    = '0;
    done    = '0;
    // Flush returns to IDLE, so a late success is simply not looked at.
    if (flush) begin
      state_n = ST_IDLE;
      ren_n   = 1'b0;
      wbv_n   = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|ent_ready && !(|dcache_busy)) begin
            take[sel] = 1'b1;
            cur_n     = sel;
            ptr_n     = ent_vj[sel] + ent_vk[sel];
            ren_n     = 1'b1;
            state_n   = ST_REQ;
          end
        end
        ST_REQ: begin
          if (dcache_read_success) begin
            ren_n   = 1'b0;
            wbv_n   = 1'b1;
            wbp_n   = ent_pos[cur];
            wbd_n   = dcache_read_value;
            state_n = ST_RESP;
          end
        end
        ST_RESP: begin
          if (wb_ready) begin
            done[cur] = 1'b1;
            wbv_n     = 1'b0;
            state_n   = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_reservation_station_multi.sv
// Scoreboard bench: expected requests and results are queued by the
// stimulus and checked by independent negedge monitors.
module tb_load_reservation_station_multi;

  localparam int DW = 32;
  localparam int FU = 16;

  typedef struct packed {
    logic [3:0]    pos;
    logic [DW-1:0] val;
  } wb_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic [3:0]        issue_pos;
  logic [3:0]        issue_qj;
  logic [DW-1:0]     issue_vj;
  logic [3:0]        issue_qk;
  logic [DW-1:0]     issue_vk;
  logic [FU-1:0]     cdb_valid;
  logic [FU*DW-1:0]  common_data_bus;
  logic              dcache_read_en;
  logic [DW-1:0]     dcache_read_ptr;
  logic [DW-1:0]     dcache_read_value;
  logic              dcache_read_success;
  logic [3:0]        dcache_busy;
  logic              wb_valid;
  logic              wb_ready;
  logic [3:0]        wb_position;
  logic [DW-1:0]     wb_value;
  logic              busy;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] req_q [$];
  logic [DW-1:0] cval_q[$];
  wb_t           wb_q  [$];

  always #5 clk = ~clk;

  load_reservation_station_multi #(
    .ENTRIES                  (4),
    .ENTRIES_LOG              (2),
    .REORDER_BUFFER_SIZE_LOG  (4),
    .FUNCTION_UNIT_NUMBER     (FU),
    .FUNCTION_UNIT_NUMBER_LOG (4),
    .NUMBER_OF_BLOCKS_IN_CACHE(4),
    .DATA_WIDTH               (DW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .issue_valid        (issue_valid),
    .issue_ready        (issue_ready),
    .issue_pos          (issue_pos),
    .issue_qj           (issue_qj),
    .issue_vj           (issue_vj),
    .issue_qk           (issue_qk),
    .issue_vk           (issue_vk),
    .cdb_valid          (cdb_valid),
    .common_data_bus    (common_data_bus),
    .dcache_read_en     (dcache_read_en),
    .dcache_read_ptr    (dcache_read_ptr),
    .dcache_read_value  (dcache_read_value),
    .dcache_read_success(dcache_read_success),
    .dcache_busy        (dcache_busy),
    .wb_valid           (wb_valid),
    .wb_ready           (wb_ready),
    .wb_position        (wb_position),
    .wb_value           (wb_value),
    .busy               (busy)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_load(input logic [DW-1:0] addr, input logic [DW-1:0] val,
                             input logic [3:0] pos, input bit has_wb);
    req_q.push_back(addr);
    cval_q.push_back(val);
    if (has_wb) wb_q.push_back({pos, val});
  endtask

  task automatic issue(input logic [3:0] p, input logic [3:0] qj,
                       input logic [DW-1:0] vj, input logic [3:0] qk,
                       input logic [DW-1:0] vk);
    issue_valid = 1'b1;
    issue_pos   = p;
    issue_qj    = qj;
    issue_vj    = vj;
    issue_qk    = qk;
    issue_vk    = vk;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic set_slot(input int k, input logic [DW-1:0] v);
    common_data_bus[k*DW +: DW] = v;
  endtask

  task automatic wait_en(input string name);
    int n = 0;
    while (!dcache_read_en && n < 30) begin
      tick();
      n++;
    end
    chk(name, dcache_read_en, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((busy || wb_valid || dcache_read_en) && n < 100) begin
      tick();
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic wait_req_left(input int left);
    int n = 0;
    while (req_q.size() > left && n < 100) begin
      tick();
      n++;
    end
    chk("req_progress", req_q.size(), left);
  endtask

  // Request and write-back monitors.
  initial begin : mon
    logic [DW-1:0] e;
    wb_t           w;
    logic          prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (dcache_read_en && !prev_en) begin
        if (req_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got addr %0h expected none",
                   dcache_read_ptr);
        end else begin
          e = req_q.pop_front();
          chk("req_addr", dcache_read_ptr, e);
        end
      end
      prev_en = dcache_read_en;
      if (wb_valid && wb_ready) begin
        if (wb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_wb: got pos %0h expected none", wb_position);
        end else begin
          w = wb_q.pop_front();
          chk("wb_pos", wb_position, w.pos);
          chk("wb_value", wb_value, w.val);
        end
      end
    end
  end

  // Data cache model: answers each request one cycle after seeing it.
  initial begin : cache
    logic [DW-1:0] v;
    int            n;
    dcache_read_success = 1'b0;
    dcache_read_value   = '0;
    forever begin
      @(negedge clk);
      if (dcache_read_en) begin
        v = (cval_q.size() != 0) ? cval_q.pop_front() : '0;
        @(posedge clk);
        #1;
        dcache_read_success = 1'b1;
        dcache_read_value   = v;
        @(posedge clk);
        #1;
        dcache_read_success = 1'b0;
        n = 0;
        while (dcache_read_en && n < 100) begin
          @(negedge clk);
          n++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    issue_valid = 1'b0;
    issue_pos = '0;
    issue_qj = '0;
    issue_vj = '0;
    issue_qk = '0;
    issue_vk = '0;
    cdb_valid = '0;
    common_data_bus = '0;
    dcache_busy = '0;
    wb_ready = 1'b1;
    repeat (3) tick();
    chk("rst_read_en", dcache_read_en, 0);
    chk("rst_read_ptr", dcache_read_ptr, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_pos", wb_position, 0);
    chk("rst_wb_value", wb_value, 0);
    chk("rst_busy", busy, 0);
    chk("rst_issue_ready", issue_ready, 1);
    reset = 1'b1;
    tick();

    // Basic load; slot 0 broadcast must be ignored.
    expect_load(32'd12, 32'hAB, 4'd3, 1'b1);
    cdb_valid[0] = 1'b1;
    set_slot(0, 32'hDEAD);
    issue(4'd3, 4'd0, 32'd5, 4'd0, 32'd7);
    cdb_valid = '0;
    chk("t1_busy", busy, 1);
    chk("t1_no_req_yet", dcache_read_en, 0);
    tick();
    chk("t1_req_latency", dcache_read_en, 1);
    drain("t1_freed");
    chk("t1_issue_ready", issue_ready, 1);

    // Base operand resolved by a later snoop.
    expect_load(32'd12, 32'h5A, 4'd1, 1'b1);
    issue(4'd1, 4'd2, 32'd0, 4'd0, 32'd7);
    tick();
    chk("t2_wait0", dcache_read_en, 0);
    cdb_valid[2] = 1'b1;
    set_slot(2, 32'd5);
    tick();
    cdb_valid = '0;
    chk("t2_capture_cycle", dcache_read_en, 0);
    tick();
    chk("t2_req_after_capture", dcache_read_en, 1);
    drain("t2_freed");

    // Issue-time bypass.
    expect_load(32'd100, 32'h64, 4'd7, 1'b1);
    cdb_valid[4] = 1'b1;
    set_slot(4, 32'd100);
    issue(4'd7, 4'd4, 32'd999, 4'd0, 32'd0);
    cdb_valid = '0;
    tick();
    chk("t3_bypass_req", dcache_read_en, 1);
    drain("t3_freed");

    // Full station, dropped issue, priority among ready entries.
    expect_load(32'h101, 32'h11, 4'd10, 1'b1);
    expect_load(32'h303, 32'h33, 4'd12, 1'b1);
    expect_load(32'h602, 32'h66, 4'd11, 1'b1);
    expect_load(32'h804, 32'h88, 4'd13, 1'b1);
    issue(4'd10, 4'd5, 32'd0, 4'd0, 32'd1);
    issue(4'd11, 4'd6, 32'd0, 4'd0, 32'd2);
    issue(4'd12, 4'd7, 32'd0, 4'd0, 32'd3);
    issue(4'd13, 4'd8, 32'd0, 4'd0, 32'd4);
    chk("t4_full_ready", issue_ready, 0);
    chk("t4_full_busy", busy, 1);
    issue(4'd9, 4'd0, 32'd1, 4'd0, 32'd1);
    tick();
    chk("t4_no_req", dcache_read_en, 0);
    cdb_valid[5] = 1'b1;
    cdb_valid[7] = 1'b1;
    set_slot(5, 32'h100);
    set_slot(7, 32'h300);
    tick();
    cdb_valid = '0;
    wait_req_left(2);
    cdb_valid[6] = 1'b1;
    cdb_valid[8] = 1'b1;
    set_slot(6, 32'h600);
    set_slot(8, 32'h800);
    tick();
    cdb_valid = '0;
    drain("t4_freed");

    // Cache busy stalls the request.
    dcache_busy = 4'b0010;
    expect_load(32'd42, 32'h2A, 4'd2, 1'b1);
    issue(4'd2, 4'd0, 32'd20, 4'd0, 32'd22);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stalled", dcache_read_en, 0);
    end
    dcache_busy = '0;
    tick();
    chk("t5_req_after_busy", dcache_read_en, 1);
    drain("t5_freed");

    // Flush in REQ; late success and the same-cycle issue are dropped.
    expect_load(32'd16, 32'h77, 4'd4, 1'b0);
    issue(4'd4, 4'd0, 32'd8, 4'd0, 32'd8);
    wait_en("t6_req");
    flush = 1'b1;
    issue_valid = 1'b1;
    issue_pos = 4'd5;
    issue_qj = 4'd0;
    issue_vj = 32'd1;
    issue_qk = 4'd0;
    issue_vk = 32'd1;
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    chk("t6_flush_en", dcache_read_en, 0);
    chk("t6_flush_busy", busy, 0);
    tick();
    tick();
    chk("t6_wb_quiet", wb_valid, 0);
    chk("t6_busy_quiet", busy, 0);
    chk("t6_no_new_req", dcache_read_en, 0);

    // Asynchronous reset while holding a result.
    wb_ready = 1'b0;
    expect_load(32'd3, 32'h55, 4'd6, 1'b0);
    issue(4'd6, 4'd0, 32'd1, 4'd0, 32'd2);
    begin
      int n = 0;
      while (!wb_valid && n < 30) begin
        tick();
        n++;
      end
    end
    chk("t7_wb_valid", wb_valid, 1);
    chk("t7_wb_pos", wb_position, 6);
    chk("t7_wb_value", wb_value, 32'h55);
    tick();
    chk("t7_hold", wb_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("t7_rst_en", dcache_read_en, 0);
    chk("t7_rst_ptr", dcache_read_ptr, 0);
    chk("t7_rst_wb_valid", wb_valid, 0);
    chk("t7_rst_wb_pos", wb_position, 0);
    chk("t7_rst_wb_value", wb_value, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_issue_ready", issue_ready, 1);
    tick();
    reset = 1'b1;
    wb_ready = 1'b1;
    repeat (4) tick();

    chk("req_queue_empty", req_q.size(), 0);
    chk("wb_queue_empty", wb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_reservation_station_multi.md
Name: load_reservation_station_multi

Overview:
Parametrised successor of the single-slot load reservation station in the Tomasulo core. Holds ENTRIES pending loads and snoops the common data bus, with a per-slot valid vector, for missing base/offset operands. Issues one ready load at a time to the data cache as address = vj + vk. Returns the loaded value and its reorder-buffer position to the write buffer through a valid/ready handshake. Adds flush support for branch recovery.

Parameters:
ENTRIES, 4, number of load slots (power of 2, at least 2)
ENTRIES_LOG, 2, log2(ENTRIES)
REORDER_BUFFER_SIZE_LOG, 4, width of ROB position tag
FUNCTION_UNIT_NUMBER, 16, CDB slot count
FUNCTION_UNIT_NUMBER_LOG, 4, width of operand tags
NUMBER_OF_BLOCKS_IN_CACHE, 4, width of dcache_busy
DATA_WIDTH, 32, operand/address/data width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of all entries and any in-flight load
issue_valid  in  1  new load offered
issue_ready  out  1  at least one free entry
issue_pos  in  REORDER_BUFFER_SIZE_LOG  ROB position of the load
issue_qj  in  FUNCTION_UNIT_NUMBER_LOG  base tag; 0 = value present
issue_vj  in  DATA_WIDTH  base value
issue_qk  in  FUNCTION_UNIT_NUMBER_LOG  offset tag; 0 = value present
issue_vk  in  DATA_WIDTH  offset value
cdb_valid  in  FUNCTION_UNIT_NUMBER  per-slot broadcast valid
common_data_bus  in  FUNCTION_UNIT_NUMBER*DATA_WIDTH  slot k at bits [k*DATA_WIDTH +: DATA_WIDTH]
dcache_read_en  out  1  read request
dcache_read_ptr  out  DATA_WIDTH  read address
dcache_read_value  in  DATA_WIDTH  read data
dcache_read_success  in  1  data valid this cycle
dcache_busy  in  NUMBER_OF_BLOCKS_IN_CACHE  any bit set blocks a new request
wb_valid  out  1  result available
wb_ready  in  1  write buffer accepts
wb_position  out  REORDER_BUFFER_SIZE_LOG  ROB position of the result
wb_value  out  DATA_WIDTH  loaded data
busy  out  1  any entry occupied

Behaviour:
- Reset (asynchronous, active-low): all entries invalid; FSM in IDLE; dcache_read_en=0; wb_valid=0; dcache_read_ptr=0; wb_position=0; wb_value=0; busy=0; issue_ready=1.
- Entry fields: valid, pos, qj, vj, qk, vk, inflight.
- Allocation: issue_valid && issue_ready writes the lowest-index free entry at the clock edge.
- Issue-time CDB bypass: if issue_qj != 0 and cdb_valid[issue_qj] in the same cycle, the entry stores qj=0 and vj=CDB slot issue_qj. The same rule applies to qk.
- Snoop: every clock, each valid entry with qX != 0 and cdb_valid[qX] captures the slot value and clears qX to 0. Tag 0 never matches.
- Ready: valid && qj==0 && qk==0 && !inflight.
- FSM, IDLE:
  - If some entry is ready, dcache_busy==0 and no flush: select the lowest-index ready entry, set its inflight bit, register dcache_read_ptr = vj+vk (mod 2^DATA_WIDTH), assert dcache_read_en, go to REQ.
  - Latency: a ready entry (registered state) is requested on the next edge.
- FSM, REQ:
  - Hold dcache_read_en and the address until dcache_read_success.
  - On dcache_read_success: drop dcache_read_en, latch wb_value and wb_position, assert wb_valid, go to RESP.
- FSM, RESP:
  - Hold wb_valid and its data stable until wb_ready.
  - On handshake: free the entry, deassert wb_valid, go to IDLE.
  - The freed slot is available for allocation in the same cycle only from the next edge; issue_ready is based on registered valids.
- One load outstanding at a time. Other entries keep snooping during REQ and RESP.
- flush has priority over all events in the cycle: all entries invalid, FSM to IDLE, dcache_read_en=0, wb_valid=0. A dcache_read_success arriving in the flush cycle or later for the aborted request is ignored. issue_valid in the flush cycle is dropped.
- Full: issue_ready=0 and issue_valid is ignored. busy = OR of entry valid bits.
- Address wrap: the sum truncates to DATA_WIDTH bits; no exception is raised.

Decomposition:
- Shared package/include: OPCODE and tag constants, TAG_NONE=0, FSM state encodings (IDLE, REQ, RESP), CDB slot-extract function.
- One sub-module, lrs_entry: a single slot's storage, snoop and bypass logic, generated ENTRIES times.
- Top level keeps the allocation and selection priority encoders and the FSM.

Test Plan:
- Issue pos=3, qj=0, vj=5, qk=0, vk=7; dcache_read_success with value 0xAB two cycles later -> dcache_read_ptr=12; wb_position=3, wb_value=0xAB; entry freed after wb_ready.
- Issue pos=1 with qj=2, vk=7; two cycles later cdb_valid[2]=1 with slot 2 = 5 -> no request before capture; request address 12 on the cycle after capture.
- Issue with qj=4 in the same cycle as cdb_valid[4], slot 4 = 100, vk=0 -> the bypass makes the entry ready immediately; address 100.
- Fill all 4 entries with unresolved tags, then a 5th issue_valid -> issue_ready=0 and the 5th load is dropped. Resolve entries 2 and 0 together -> entry 0 is requested first, then entry 2.
- Hold dcache_busy=4'b0010 while an entry is ready -> dcache_read_en stays 0; request goes out on the cycle after busy clears.
- flush while in REQ; success arrives next cycle -> wb_valid stays 0, busy=0. Assert reset low mid-RESP -> all outputs return to reset values immediately.
